// File: rtl/sram_arbiter.sv
// Two-master (inst/data) to single-bus arbiter with an in-order outstanding-ID FIFO.
// Optional macro ARB_ROUND_ROBIN_EN switches IDLE arbitration from fixed data priority to round-robin.
module sram_arbiter #(
    parameter int OT_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inst_req,
    input  logic [31:0]                   inst_addr,
    input  logic [1:0]                    inst_size,
    output logic                          inst_addr_ok,
    output logic                          inst_data_ok,
    output logic [31:0]                   inst_rdata,
    input  logic                          data_req,
    input  logic                          data_wr,
    input  logic [1:0]                    data_size,
    input  logic [3:0]                    data_wstrb,
    input  logic [31:0]                   data_addr,
    input  logic [31:0]                   data_wdata,
    output logic                          data_addr_ok,
    output logic                          data_data_ok,
    output logic [31:0]                   data_rdata,
    output logic                          bus_req,
    output logic                          bus_wr,
    output logic [1:0]                    bus_size,
    output logic [3:0]                    bus_wstrb,
    output logic [31:0]                   bus_addr,
    output logic [31:0]                   bus_wdata,
    input  logic                          bus_addr_ok,
    input  logic                          bus_data_ok,
    input  logic [31:0]                   bus_rdata,
    output logic [$clog2(OT_DEPTH):0]     ot_count,
    output logic                          err
);
    localparam int PW = $clog2(OT_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD_I = 2'd1;
    localparam logic [1:0] HOLD_D = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          fifo_q [OT_DEPTH];
    logic          fifo_d [OT_DEPTH];

    logic req_int;
    logic gnt_data;
    logic prefer_data;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic head;

`ifdef ARB_ROUND_ROBIN_EN
    // last_win_q = 1 means data won the previous accepted handshake
    logic last_win_q, last_win_d;

    assign prefer_data = ~last_win_q;

    always_comb begin
        last_win_d = last_win_q;
        if (push) last_win_d = gnt_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_win_q <= 1'b0;
        else      last_win_q <= last_win_d;
    end
`else
    assign prefer_data = 1'b1;
`endif

    assign fifo_full  = (cnt_q == CW'(OT_DEPTH));
    assign fifo_empty = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        req_int  = 1'b0;
        gnt_data = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_full && (inst_req || data_req)) begin
                    req_int  = 1'b1;
                    gnt_data = data_req && (!inst_req || prefer_data);
                end
            end
            HOLD_I: req_int = 1'b1;
            HOLD_D: begin
                req_int  = 1'b1;
                gnt_data = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (req_int) state_d = bus_addr_ok ? IDLE : (gnt_data ? HOLD_D : HOLD_I);
    end

    assign push = req_int && bus_addr_ok;
    assign pop  = bus_data_ok && !fifo_empty;
    assign head = fifo_q[rd_ptr_q];

    // Pointers are exactly PW bits wide, so they wrap modulo OT_DEPTH on their own
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = gnt_data;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        err_d = err_q | (bus_data_ok && fifo_empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    // Handshake outputs are forced low while reset is held, independent of the clock
    assign bus_req      = req_int & rst;
    assign inst_addr_ok = bus_addr_ok & bus_req & ~gnt_data;
    assign data_addr_ok = bus_addr_ok & bus_req & gnt_data;
    assign inst_data_ok = pop & ~head & rst;
    assign data_data_ok = pop & head & rst;

    assign bus_wr    = gnt_data & data_wr;
    assign bus_size  = gnt_data ? data_size  : inst_size;
    assign bus_wstrb = gnt_data ? data_wstrb : 4'h0;
    assign bus_addr  = gnt_data ? data_addr  : inst_addr;
    assign bus_wdata = gnt_data ? data_wdata : 32'h0;

    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;
    assign ot_count   = cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed, table-driven bench for sram_arbiter (OT_DEPTH=4), fixed or round-robin build.
module tb_sram_arbiter;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [31:0] IA = 32'h1000_0040;
    localparam logic [31:0] DA = 32'h2000_0080;
    localparam logic [31:0] DW = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic [1:0]  inst_size;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [2:0]  ot_count;
    logic        err;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.OT_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .ot_count(ot_count), .err(err)
    );

    typedef struct {
        logic        ir, dr, aok, dok;
        logic [31:0] rd;
        logic        breq, gd, iaok, daok, idok, ddok;
        logic [2:0]  ot;
        logic        err;
    } vec_t;

    function automatic vec_t mk(logic ir, logic dr, logic aok, logic dok, logic [31:0] rd,
                                logic breq, logic gd, logic iaok, logic daok,
                                logic idok, logic ddok, logic [2:0] ot, logic e);
        vec_t v;
        v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.rd = rd;
        v.breq = breq; v.gd = gd; v.iaok = iaok; v.daok = daok;
        v.idok = idok; v.ddok = ddok; v.ot = ot; v.err = e;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, check outputs before the next rising edge
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        inst_req = v.ir; data_req = v.dr; bus_addr_ok = v.aok;
        bus_data_ok = v.dok; bus_rdata = v.rd;
        #1;
        check({tag, " bus_req"}, bus_req, v.breq);
        if (v.breq) begin
            check({tag, " bus_addr"}, bus_addr, v.gd ? DA : IA);
            check({tag, " bus_wr"}, bus_wr, v.gd);
            check({tag, " bus_wstrb"}, bus_wstrb, v.gd ? 4'hA : 4'h0);
            check({tag, " bus_wdata"}, bus_wdata, v.gd ? DW : 32'h0);
            check({tag, " bus_size"}, bus_size, v.gd ? 2'd1 : 2'd2);
        end
        check({tag, " inst_addr_ok"}, inst_addr_ok, v.iaok);
        check({tag, " data_addr_ok"}, data_addr_ok, v.daok);
        check({tag, " inst_data_ok"}, inst_data_ok, v.idok);
        check({tag, " data_data_ok"}, data_data_ok, v.ddok);
        check({tag, " inst_rdata"}, inst_rdata, v.rd);
        check({tag, " data_rdata"}, data_rdata, v.rd);
        check({tag, " ot_count"}, ot_count, v.ot);
        check({tag, " err"}, err, v.err);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " bus_req"}, bus_req, 1'b0);
        check({tag, " inst_addr_ok"}, inst_addr_ok, 1'b0);
        check({tag, " data_addr_ok"}, data_addr_ok, 1'b0);
        check({tag, " inst_data_ok"}, inst_data_ok, 1'b0);
        check({tag, " data_data_ok"}, data_data_ok, 1'b0);
        check({tag, " ot_count"}, ot_count, 3'd0);
        check({tag, " err"}, err, 1'b0);
    endtask

    vec_t vecs[22];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Columns: ir dr aok dok rdata | breq gd iaok daok idok ddok ot err
        vecs[0]  = mk(1, 0, 1, 0, 32'h0,         1, 0,   1,  0,   0,  0,   3'd0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,         0, 0,   0,  0,   0,  0,   3'd1, 0);
        vecs[2]  = mk(0, 0, 0, 1, 32'h1234_5678, 0, 0,   0,  0,   1,  0,   3'd1, 0);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,         0, 0,   0,  0,   0,  0,   3'd0, 0);
        vecs[4]  = mk(1, 1, 0, 0, 32'h0,         1, 1,   0,  0,   0,  0,   3'd0, 0);
        vecs[5]  = mk(1, 1, 0, 0, 32'h0,         1, 1,   0,  0,   0,  0,   3'd0, 0);
        vecs[6]  = mk(1, 0, 0, 0, 32'h0,         1, 1,   0,  0,   0,  0,   3'd0, 0);
        vecs[7]  = mk(1, 1, 1, 0, 32'h0,         1, 1,   0,  1,   0,  0,   3'd0, 0);
        vecs[8]  = mk(1, 1, 1, 0, 32'h0,         1, !RR, RR, !RR, 0,  0,   3'd1, 0);
        vecs[9]  = mk(0, 0, 0, 1, 32'hA5A5_0001, 0, 0,   0,  0,   0,  1,   3'd2, 0);
        vecs[10] = mk(0, 0, 0, 1, 32'hA5A5_0002, 0, 0,   0,  0,   RR, !RR, 3'd1, 0);
        vecs[11] = mk(1, 0, 1, 0, 32'h0,         1, 0,   1,  0,   0,  0,   3'd0, 0);
        vecs[12] = mk(0, 1, 1, 0, 32'h0,         1, 1,   0,  1,   0,  0,   3'd1, 0);
        vecs[13] = mk(1, 0, 1, 0, 32'h0,         1, 0,   1,  0,   0,  0,   3'd2, 0);
        vecs[14] = mk(0, 0, 0, 1, 32'hAAAA_0001, 0, 0,   0,  0,   1,  0,   3'd3, 0);
        vecs[15] = mk(0, 0, 0, 1, 32'hBBBB_0002, 0, 0,   0,  0,   0,  1,   3'd2, 0);
        vecs[16] = mk(0, 0, 0, 1, 32'hCCCC_0003, 0, 0,   0,  0,   1,  0,   3'd1, 0);
        vecs[17] = mk(0, 0, 0, 0, 32'h0,         0, 0,   0,  0,   0,  0,   3'd0, 0);
        vecs[18] = mk(1, 0, 1, 0, 32'h0,         1, 0,   1,  0,   0,  0,   3'd0, 0);
        vecs[19] = mk(1, 0, 1, 1, 32'h0000_0055, 1, 0,   1,  0,   1,  0,   3'd1, 0);
        vecs[20] = mk(0, 0, 0, 1, 32'h0000_0066, 0, 0,   0,  0,   1,  0,   3'd1, 0);
        vecs[21] = mk(0, 0, 0, 0, 32'h0,         0, 0,   0,  0,   0,  0,   3'd0, 0);

        inst_addr = IA; inst_size = 2'd2;
        data_addr = DA; data_size = 2'd1; data_wr = 1'b1; data_wstrb = 4'hA; data_wdata = DW;
        bus_rdata = 32'h0;

        // Reset held with every request active: handshakes must stay low
        rst = 1'b0;
        inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        #2;
        check_quiet("reset");
        inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        #10 rst = 1'b1;

        for (int i = 0; i < 22; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Fill the outstanding FIFO, then a same-cycle pop must not unblock arbitration
        for (int i = 0; i < 4; i++)
            apply(mk(1, 0, 1, 0, 32'h0, 1, 0, 1, 0, 0, 0, 3'(i), 0), $sformatf("fill%0d", i));
        apply(mk(1, 0, 1, 0, 32'h0,       0, 0, 0, 0, 0, 0, 3'd4, 0), "full_block");
        apply(mk(1, 0, 1, 1, 32'h0000_0011, 0, 0, 0, 0, 1, 0, 3'd4, 0), "full_pop");
        apply(mk(1, 0, 1, 0, 32'h0,       1, 0, 1, 0, 0, 0, 3'd3, 0), "full_resume");
        for (int i = 0; i < 4; i++)
            apply(mk(0, 0, 0, 1, 32'h0000_0020 + i, 0, 0, 0, 0, 1, 0, 3'(4 - i), 0),
                  $sformatf("drain%0d", i));

        // Response with nothing outstanding sets a sticky error
        apply(mk(0, 0, 0, 1, 32'h0000_0099, 0, 0, 0, 0, 0, 0, 3'd0, 0), "err_set");
        apply(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 3'd0, 1), "err_hold0");
        apply(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 3'd0, 1), "err_hold1");
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("err_clear", err, 1'b0);
        @(negedge clk) rst = 1'b1;
        apply(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 3'd0, 0), "err_after_rst");

        // Asynchronous reset mid-cycle with three transactions outstanding
        for (int i = 0; i < 3; i++)
            apply(mk(1, 0, 1, 0, 32'h0, 1, 0, 1, 0, 0, 0, 3'(i), 0), $sformatf("ot%0d", i));
        apply(mk(1, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 3'd3, 0), "hold_i");
        #2;
        bus_data_ok = 1'b1; bus_addr_ok = 1'b1;
        rst = 1'b0;
        #1 check_quiet("async_rst");
        @(posedge clk);
        #1 check("async_rst_edge ot_count", ot_count, 3'd0);
        @(negedge clk);
        inst_req = 1'b0; bus_data_ok = 1'b0; bus_addr_ok = 1'b0;
        rst = 1'b1;
        apply(mk(0, 0, 0, 1, 32'h0000_0077, 0, 0, 0, 0, 0, 0, 3'd0, 0), "stale_rsp");
        apply(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 3'd0, 1), "stale_err");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
